// File: rtl/instr_prefetch_pkg.sv
// Shared CPU parameter header for the prefetch stage and the control unit.
// Holds the default word/address widths, the ROM read latency and the
// position of the opcode field inside the first instruction word. The
// control unit and the prefetch stage both take their defaults from here
// so that they always agree on the instruction format.
package instr_prefetch_pkg;

    // Instruction word width, ROM address width, ROM read latency in cycles.
    localparam int CPU_DATA_W     = 14;
    localparam int CPU_ADDR_W     = 12;
    localparam int CPU_ROM_LAT    = 2;
    // Default depth of the prefetch word FIFO (power of two, at least 2).
    localparam int PREFETCH_DEPTH = 4;

    // The opcode occupies the top OPCODE_W bits of word0:
    // bits [data_w-1 : data_w-OPCODE_W].
    localparam int OPCODE_W = 4;

    function automatic int opcode_lsb(input int data_w);
        return data_w - OPCODE_W;
    endfunction

endpackage

// File: rtl/instr_prefetch_fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of ROM words, each tagged with its ROM address.
// One word can be pushed per cycle; a pop removes two entries at once (one
// instruction pair). The head entry and the entry after it are read out
// combinationally, so they stay stable while nothing is popped.
// Ports:
//   clk, reset       clock, synchronous active-high reset (also clears storage)
//   flush            synchronous empty; wins over push and pop in the same cycle
//   push, push_data, push_addr   write one word and its address
//   pop2             remove the two head entries (caller guarantees count >= 2)
//   count            number of stored entries (0..DEPTH)
//   head_data, head_addr, next_data   head entry and head+1 entry
module fetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DEPTH  = PREFETCH_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic                     pop2,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DATA_W-1:0]        head_data,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [DATA_W-1:0]        next_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_next;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign rd_ptr_next = rd_ptr + PTR_W'(1);

    assign head_data = data_mem[rd_ptr];
    assign head_addr = addr_mem[rd_ptr];
    assign next_data = data_mem[rd_ptr_next];

    // Storage is cleared only on reset so the read-out words are defined
    // from the first cycle; a flush just rewinds the pointers and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= push_data;
                addr_mem[wr_ptr] <= push_addr;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop2) begin
                rd_ptr <= rd_ptr + PTR_W'(2);
            end
            count <= count + CNT_W'(push) - (pop2 ? CNT_W'(2) : CNT_W'(0));
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: instruction prefetch stage between the program ROM and the
// CPU control unit. Issues sequential one-word ROM reads, absorbs the fixed
// ROM latency with an in-flight shift register, buffers returned words in a
// small FIFO and presents two-word instructions over valid/ready.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rom_rd, rom_addr      ROM read request and address (one word per cycle)
//   rom_data              word for the request issued ROM_LAT cycles earlier
//   instr_valid/ready     instruction pair handshake towards control
//   instr_word0/1         first/second word of the pair (opcode in word0 top bits)
//   instr_addr            ROM address of instr_word0
//   redirect, redirect_addr  jump taken: flush everything and refetch at target
//   halt                  stop issuing new requests while high
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int ROM_LAT = CPU_ROM_LAT,
    parameter int DEPTH   = PREFETCH_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_word0,
    output logic [DATA_W-1:0] instr_word1,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  pc;
    logic [ROM_LAT-1:0] slot_v;
    logic [ADDR_W-1:0]  slot_addr [ROM_LAT];
    logic [CNT_W-1:0]   fifo_count;
    logic [15:0]        credit_used;
    logic               issue;
    logic               pop2;

    // Credits in use = words already buffered plus words still in flight.
    // A pop in the same cycle is deliberately not credited back, so the FIFO
    // can never be overrun by returning data.
    always_comb begin
        credit_used = 16'(fifo_count);
        for (int i = 0; i < ROM_LAT; i++) begin
            credit_used = credit_used + 16'(slot_v[i]);
        end
    end

    assign issue    = ~reset & ~redirect & ~halt & (credit_used < 16'(DEPTH));
    assign rom_rd   = issue;
    assign rom_addr = pc;

    assign instr_valid = (fifo_count >= CNT_W'(2));
    // A pop that coincides with a redirect is dropped; the flush wins anyway.
    assign pop2        = instr_valid & instr_ready & ~redirect;

    // Fetch PC: a redirect reloads it, otherwise it advances by one word per
    // issued request and wraps at the top of the ROM.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else if (redirect) begin
            pc <= redirect_addr;
        end else if (issue) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // In-flight tracker: slot i holds the request issued i+1 cycles ago, so
    // the last slot lines up with the word currently on rom_data. A redirect
    // kills every outstanding request so stale words never reach the FIFO.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            slot_v <= '0;
        end else begin
            slot_v[0] <= issue;
            for (int i = 1; i < ROM_LAT; i++) begin
                slot_v[i] <= slot_v[i-1];
            end
        end
    end

    // Addresses travel alongside the valid bits; they only matter when the
    // matching valid bit is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                slot_addr[i] <= '0;
            end
        end else begin
            slot_addr[0] <= pc;
            for (int i = 1; i < ROM_LAT; i++) begin
                slot_addr[i] <= slot_addr[i-1];
            end
        end
    end

    fetch_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (slot_v[ROM_LAT-1]),
        .push_data (rom_data),
        .push_addr (slot_addr[ROM_LAT-1]),
        .pop2      (pop2),
        .count     (fifo_count),
        .head_data (instr_word0),
        .head_addr (instr_addr),
        .next_data (instr_word1)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Testbench for instr_prefetch: a latency-accurate ROM model (ROM[n] = n)
// feeds the DUT; expected instruction pairs are queued as each scenario is
// set up and compared when the DUT hands a pair over.
module tb_instr_prefetch;
    import instr_prefetch_pkg::*;

    localparam int DATA_W  = CPU_DATA_W;
    localparam int ADDR_W  = CPU_ADDR_W;
    localparam int ROM_LAT = CPU_ROM_LAT;
    localparam int DEPTH   = PREFETCH_DEPTH;
    localparam int PAIR_W  = 2 * DATA_W + ADDR_W;

    typedef logic [PAIR_W-1:0] pair_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_word0;
    logic [DATA_W-1:0] instr_word1;
    logic [ADDR_W-1:0] instr_addr;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              halt;

    int    total = 0;
    int    bad   = 0;
    pair_t sb[$];
    pair_t exp_pair;
    pair_t got_pair;

    always #5 clk = ~clk;

    instr_prefetch #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .ROM_LAT(ROM_LAT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_word0  (instr_word0),
        .instr_word1  (instr_word1),
        .instr_addr   (instr_addr),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .halt         (halt)
    );

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    // ROM: a request seen in cycle t is answered during cycle t+ROM_LAT;
    // with no request behind it the bus carries all-ones garbage.
    logic [ROM_LAT-1:0] pipe_v = '0;
    logic [ADDR_W-1:0]  pipe_a [ROM_LAT];

    always @(posedge clk) begin
        pipe_v[0] <= rom_rd;
        pipe_a[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign rom_data = pipe_v[ROM_LAT-1] ? rom_word(pipe_a[ROM_LAT-1]) : '1;

    function automatic pair_t mk_pair(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] b;
        b = a + ADDR_W'(1);
        return {rom_word(a), rom_word(b), a};
    endfunction

    task automatic push_pairs(input logic [ADDR_W-1:0] start, input int n);
        logic [ADDR_W-1:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back(mk_pair(a));
            a = a + ADDR_W'(2);
        end
    endtask

    // Advance to just after the next rising edge; inputs set afterwards
    // apply to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_addr = '0; halt = 1'b0; instr_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if ({rom_rd, instr_valid, rom_addr} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got rd=%b valid=%b addr=%h exp 0/0/000", rom_rd, instr_valid, rom_addr);
        end
        total++;
        if ({instr_word0, instr_word1, instr_addr} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_data got w0=%h w1=%h addr=%h exp zeros", instr_word0, instr_word1, instr_addr);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (rom_rd !== 1'b1 || rom_addr !== '0) begin
            bad++;
            $display("[TB] FAIL reset_first_req got rd=%b addr=%h exp 1/000", rom_rd, rom_addr);
        end
        tick();
    endtask

    task automatic test_free_run();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        instr_ready = 1'b1;
        push_pairs('0, 3);
        for (int cyc = 1; cyc <= 60 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (cyc <= 3) begin
                total++;
                if (rom_rd !== 1'b1 || rom_addr !== ADDR_W'(cyc - 1)) begin
                    bad++;
                    $display("[TB] FAIL free_run_req cycle %0d got rd=%b addr=%h exp 1/%h", cyc, rom_rd, rom_addr, cyc - 1);
                end
            end
            if (cyc == 4 || cyc == 5) begin
                total++;
                if (instr_valid !== (cyc == 5)) begin
                    bad++;
                    $display("[TB] FAIL free_run_valid cycle %0d got %b exp %b", cyc, instr_valid, cyc == 5);
                end
            end
            if (instr_valid && instr_ready) begin
                exp_pair = sb.pop_front();
                got_pair = {instr_word0, instr_word1, instr_addr};
                total++;
                if (got_pair !== exp_pair) begin
                    bad++;
                    $display("[TB] FAIL free_run_pair got=%h exp=%h", got_pair, exp_pair);
                end
            end
            tick();
        end
        instr_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL free_run_drain left=%0d exp 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_backpressure();
        int n_rd;
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_addr = 12'h040;
        tick();
        redirect = 1'b0;
        n_rd = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (rom_rd) n_rd++;
            if (cyc >= 5) begin
                got_pair = {instr_word0, instr_word1, instr_addr};
                total++;
                if (instr_valid !== 1'b1 || got_pair !== mk_pair(12'h040)) begin
                    bad++;
                    $display("[TB] FAIL backpressure_hold cycle %0d got valid=%b pair=%h exp 1/%h", cyc, instr_valid, got_pair, mk_pair(12'h040));
                end
            end
            tick();
        end
        total++;
        if (n_rd != DEPTH) begin
            bad++;
            $display("[TB] FAIL backpressure_reqs got %0d exp %0d", n_rd, DEPTH);
        end
        push_pairs(12'h040, 4);
        instr_ready = 1'b1;
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                exp_pair = sb.pop_front();
                got_pair = {instr_word0, instr_word1, instr_addr};
                total++;
                if (got_pair !== exp_pair) begin
                    bad++;
                    $display("[TB] FAIL backpressure_pair got=%h exp=%h", got_pair, exp_pair);
                end
            end
            tick();
        end
        instr_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL backpressure_drain left=%0d exp 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_redirect_inflight();
        bit seen_valid;
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_addr = 12'h200;
        tick();
        redirect = 1'b0;
        tick(); tick();
        // two requests to 0x200/0x201 are outstanding in this cycle
        redirect = 1'b1; redirect_addr = 12'h123; instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        seen_valid = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (instr_valid) seen_valid = 1'b1;
            tick();
        end
        total++;
        if (seen_valid) begin
            bad++;
            $display("[TB] FAIL redirect_early_valid got 1 exp 0");
        end
        push_pairs(12'h123, 3);
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                exp_pair = sb.pop_front();
                got_pair = {instr_word0, instr_word1, instr_addr};
                total++;
                if (got_pair !== exp_pair) begin
                    bad++;
                    $display("[TB] FAIL redirect_pair got=%h exp=%h", got_pair, exp_pair);
                end
            end
            tick();
        end
        instr_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL redirect_drain left=%0d exp 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_wrap();
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_addr = 12'hFFE;
        tick();
        redirect = 1'b0;
        instr_ready = 1'b1;
        push_pairs(12'hFFE, 3);
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                exp_pair = sb.pop_front();
                got_pair = {instr_word0, instr_word1, instr_addr};
                total++;
                if (got_pair !== exp_pair) begin
                    bad++;
                    $display("[TB] FAIL wrap_pair got=%h exp=%h", got_pair, exp_pair);
                end
            end
            tick();
        end
        instr_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL wrap_drain left=%0d exp 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_halt();
        halt = 1'b0; instr_ready = 1'b1; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        push_pairs('0, 1);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 4) halt = 1'b1;
            @(negedge clk);
            total++;
            if ((rom_rd !== (cyc <= 3)) || (cyc <= 3 && rom_addr !== ADDR_W'(cyc - 1))) begin
                bad++;
                $display("[TB] FAIL halt_req cycle %0d got rd=%b addr=%h", cyc, rom_rd, rom_addr);
            end
            if (instr_valid && instr_ready) begin
                got_pair = {instr_word0, instr_word1, instr_addr};
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL halt_extra_pair got=%h exp none", got_pair);
                end else begin
                    exp_pair = sb.pop_front();
                    if (got_pair !== exp_pair) begin
                        bad++;
                        $display("[TB] FAIL halt_pair got=%h exp=%h", got_pair, exp_pair);
                    end
                end
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL halt_state got valid=%b pending=%0d exp 0/0", instr_valid, sb.size());
            sb.delete();
        end
        tick();
        halt = 1'b0;
        @(negedge clk);
        total++;
        if (rom_rd !== 1'b1 || rom_addr !== 12'h003) begin
            bad++;
            $display("[TB] FAIL halt_resume got rd=%b addr=%h exp 1/003", rom_rd, rom_addr);
        end
        tick();
        push_pairs(12'h002, 2);
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                exp_pair = sb.pop_front();
                got_pair = {instr_word0, instr_word1, instr_addr};
                total++;
                if (got_pair !== exp_pair) begin
                    bad++;
                    $display("[TB] FAIL halt_resume_pair got=%h exp=%h", got_pair, exp_pair);
                end
            end
            tick();
        end
        instr_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL halt_drain left=%0d exp 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_simultaneous();
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_addr = 12'h300;
        tick();
        redirect = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL simul_setup_valid got %b exp 1", instr_valid);
        end
        tick();
        // redirect, valid and ready all high together: nothing may be consumed
        redirect = 1'b1; redirect_addr = 12'h010; instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL simul_flush_valid got %b exp 0", instr_valid);
        end
        tick();
        push_pairs(12'h010, 2);
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                exp_pair = sb.pop_front();
                got_pair = {instr_word0, instr_word1, instr_addr};
                total++;
                if (got_pair !== exp_pair) begin
                    bad++;
                    $display("[TB] FAIL simul_pair got=%h exp=%h", got_pair, exp_pair);
                end
            end
            tick();
        end
        instr_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL simul_drain left=%0d exp 0", sb.size());
            sb.delete();
        end
        // reset and redirect in the same cycle: reset wins, PC restarts at 0
        reset = 1'b1; redirect = 1'b1; redirect_addr = 12'h0AB;
        tick();
        reset = 1'b0; redirect = 1'b0;
        @(negedge clk);
        total++;
        if (rom_rd !== 1'b1 || rom_addr !== '0 || instr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL simul_reset_redirect got rd=%b addr=%h valid=%b exp 1/000/0", rom_rd, rom_addr, instr_valid);
        end
        tick();
    endtask

    initial begin
        $display("[TB] starting instr_prefetch bench");
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect_inflight();
        test_wrap();
        test_halt();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
